// File: rtl/irq_ctrl_pkg.sv
// irq_ctrl_pkg: shared constants for the interrupt controller.
//   - bus widths and the word addresses of the four controller registers
//   - position of the valid flag in the CLAIM word and the timer source index
//   - FSM state encoding
//   - helper that builds the CLAIM read word from a source id
package irq_ctrl_pkg;

    localparam int unsigned IRQ_ADDR_W = 32;
    localparam int unsigned IRQ_DATA_W = 32;

    localparam logic [IRQ_ADDR_W-1:0] IRQ_PEND_ADDR  = 32'h5000_0000;
    localparam logic [IRQ_ADDR_W-1:0] IRQ_EN_ADDR    = 32'h5000_0004;
    localparam logic [IRQ_ADDR_W-1:0] IRQ_CLAIM_ADDR = 32'h5000_0008;
    localparam logic [IRQ_ADDR_W-1:0] IRQ_EOI_ADDR   = 32'h5000_000C;

    localparam int unsigned IRQ_CLAIM_VALID_BIT = 31;
    localparam int unsigned IRQ_TIM_SRC         = 0;

    typedef enum logic [1:0] {
        IRQ_ST_IDLE   = 2'd0,
        IRQ_ST_ASSERT = 2'd1,
        IRQ_ST_ACTIVE = 2'd2
    } irq_state_e;

    // CLAIM word: valid flag on top, id right-aligned, zeros in between.
    function automatic logic [IRQ_DATA_W-1:0] irq_claim_word(
        input logic [IRQ_CLAIM_VALID_BIT-1:0] id
    );
        irq_claim_word = {1'b1, id};
    endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// irq_prio_enc: combinational lowest-index-first priority encoder.
// Ports:
//   vec  in   N_SRC   request vector (bit 0 = highest priority)
//   any  out  1       at least one request set
//   id   out  ID_W    index of the lowest set bit (0 when none)
module irq_prio_enc
    import irq_ctrl_pkg::*;
#(
    parameter int unsigned N_SRC = 8,
    parameter int unsigned ID_W  = 5
) (
    input  logic [N_SRC-1:0] vec,
    output logic             any,
    output logic [ID_W-1:0]  id
);

    // Scan from the top down so the lowest set index is the last one written.
    always_comb begin
        any = |vec;
        id  = {ID_W{1'b0}};
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (vec[i]) begin
                id = ID_W'(i);
            end else begin
                id = id;
            end
        end
    end

endmodule

// File: rtl/irq_ctrl.sv
// irq_ctrl: memory-mapped interrupt controller sharing one core interrupt line
// between the timer (source 0) and further peripherals.
// Ports:
//   clk             in   clock, all logic on posedge
//   rst_n           in   synchronous active-low reset
//   irq_r_addr_i    in   read address
//   irq_w_addr_i    in   write address
//   irq_data_i      in   write data
//   irq_r_enable_i  in   read strobe
//   irq_w_enable_i  in   write strobe
//   irq_src_i       in   level-high source lines (clk domain)
//   irq_data_o      out  registered read data (1-cycle latency, holds otherwise)
//   irq_o           out  interrupt request to the core
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int unsigned N_SRC = 8,
    parameter int unsigned ID_W  = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [IRQ_ADDR_W-1:0] irq_r_addr_i,
    input  logic [IRQ_ADDR_W-1:0] irq_w_addr_i,
    input  logic [IRQ_DATA_W-1:0] irq_data_i,
    input  logic                  irq_r_enable_i,
    input  logic                  irq_w_enable_i,
    input  logic [N_SRC-1:0]      irq_src_i,
    output logic [IRQ_DATA_W-1:0] irq_data_o,
    output logic                  irq_o
);

    // Widened vectors so a cur_id index is always in range whatever N_SRC is.
    localparam int unsigned EXT_W = 1 << ID_W;

    irq_state_e             state_r, state_nxt_s;
    logic [ID_W-1:0]        cur_id_r, cur_id_nxt_s;
    logic [N_SRC-1:0]       pend_r, en_r, src_q_r;
    logic [IRQ_DATA_W-1:0]  rdata_r, rdata_nxt_s;
    logic                   irq_r;

    logic [EXT_W-1:0]       en_ext_s;
    logic [EXT_W-1:0]       clr_ext_s;
    logic [N_SRC-1:0]       rise_s;
    logic                   claim_rd_s, claim_hit_s, eoi_wr_s, en_wr_s;
    logic                   enc_any_s;
    logic [ID_W-1:0]        enc_id_s;
    logic                   unused_s;

    assign claim_rd_s  = irq_r_enable_i && (irq_r_addr_i == IRQ_CLAIM_ADDR);
    assign eoi_wr_s    = irq_w_enable_i && (irq_w_addr_i == IRQ_EOI_ADDR);
    assign en_wr_s     = irq_w_enable_i && (irq_w_addr_i == IRQ_EN_ADDR);
    assign rise_s      = irq_src_i & ~src_q_r;
    assign en_ext_s    = EXT_W'(en_r);
    // A claim only counts while the claimed source is still enabled.
    assign claim_hit_s = claim_rd_s && (state_r == IRQ_ST_ASSERT) && en_ext_s[cur_id_r];
    assign unused_s    = ^{irq_data_i, clr_ext_s};

    irq_prio_enc #(
        .N_SRC (N_SRC),
        .ID_W  (ID_W)
    ) u_prio_enc (
        .vec (pend_r & en_r),
        .any (enc_any_s),
        .id  (enc_id_s)
    );

    // Next-state logic of the claim/EOI handshake and the pend clear mask.
    always_comb begin
        state_nxt_s  = state_r;
        cur_id_nxt_s = cur_id_r;
        clr_ext_s    = {EXT_W{1'b0}};
        case (state_r)
            IRQ_ST_IDLE: begin
                if (enc_any_s) begin
                    cur_id_nxt_s = enc_id_s;
                    state_nxt_s  = IRQ_ST_ASSERT;
                end else begin
                    state_nxt_s  = IRQ_ST_IDLE;
                end
            end
            IRQ_ST_ASSERT: begin
                // Source disabled before software claimed it: withdraw, keep pend.
                if (!en_ext_s[cur_id_r]) begin
                    state_nxt_s = IRQ_ST_IDLE;
                end else if (claim_rd_s) begin
                    state_nxt_s = IRQ_ST_ACTIVE;
                    clr_ext_s   = EXT_W'(1) << cur_id_r;
                end else begin
                    state_nxt_s = IRQ_ST_ASSERT;
                end
            end
            IRQ_ST_ACTIVE: begin
                if (eoi_wr_s && (irq_data_i[ID_W-1:0] == cur_id_r)) begin
                    state_nxt_s = IRQ_ST_IDLE;
                end else begin
                    state_nxt_s = IRQ_ST_ACTIVE;
                end
            end
            default: begin
                state_nxt_s = IRQ_ST_IDLE;
            end
        endcase
    end

    // Read data mux; CLAIM sees the pre-update state of this cycle.
    always_comb begin
        rdata_nxt_s = {IRQ_DATA_W{1'b0}};
        case (irq_r_addr_i)
            IRQ_PEND_ADDR:  rdata_nxt_s = IRQ_DATA_W'(pend_r);
            IRQ_EN_ADDR:    rdata_nxt_s = IRQ_DATA_W'(en_r);
            IRQ_CLAIM_ADDR: begin
                if (claim_hit_s) begin
                    rdata_nxt_s = irq_claim_word(IRQ_CLAIM_VALID_BIT'(cur_id_r));
                end else begin
                    rdata_nxt_s = {IRQ_DATA_W{1'b0}};
                end
            end
            default:        rdata_nxt_s = {IRQ_DATA_W{1'b0}};
        endcase
    end

    // State, source history, pending/enable registers and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r  <= IRQ_ST_IDLE;
            cur_id_r <= {ID_W{1'b0}};
            pend_r   <= {N_SRC{1'b0}};
            en_r     <= {N_SRC{1'b0}};
            src_q_r  <= {N_SRC{1'b0}};
            rdata_r  <= {IRQ_DATA_W{1'b0}};
            irq_r    <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            cur_id_r <= cur_id_nxt_s;
            src_q_r  <= irq_src_i;
            // A new edge on the bit being claimed wins over the clear.
            pend_r   <= (pend_r & ~clr_ext_s[N_SRC-1:0]) | rise_s;
            irq_r    <= (state_nxt_s == IRQ_ST_ASSERT);
            if (en_wr_s) begin
                en_r <= irq_data_i[N_SRC-1:0];
            end else begin
                en_r <= en_r;
            end
            if (irq_r_enable_i) begin
                rdata_r <= rdata_nxt_s;
            end else begin
                rdata_r <= rdata_r;
            end
        end
    end

    assign irq_data_o = rdata_r;
    assign irq_o      = irq_r;

endmodule
